// File: rtl/xaui_link_reset_ctrl_if.sv
// Status and control bundle between the XAUI bring-up sequencer and the core/host side.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; all signals are level status or single-cycle requests.
interface xaui_link_reset_ctrl_if;
   logic       soft_reset_req;
   logic [3:0] lane_sync;
   logic       align_status;
   logic       xaui_reset;
   logic       link_up;
   logic       link_fail;
   logic [3:0] retry_count;
   logic [2:0] ctrl_state;

   // Sequencer side: consumes core status and host request, drives resets and status.
   modport master (
      input  soft_reset_req, lane_sync, align_status,
      output xaui_reset, link_up, link_fail, retry_count, ctrl_state
   );

   // Core/host side: drives status and request, observes the sequencer.
   modport slave (
      output soft_reset_req, lane_sync, align_status,
      input  xaui_reset, link_up, link_fail, retry_count, ctrl_state
   );
endinterface

// File: rtl/xaui_link_reset_ctrl.sv
// XAUI bring-up sequencer: reset hold, wait for sync/align, stability check, retry and fail latch.
// Latency: outputs are registered and follow the state one clock after the deciding input sample.
// Backpressure: none; the core status is sampled every cycle and the host request is never stalled.
module xaui_link_reset_ctrl #(
   parameter int HOLD_CYCLES   = 16,
   parameter int SETTLE_CYCLES = 1024,
   parameter int STABLE_CYCLES = 256,
   parameter int MAX_RETRIES   = 7,
   parameter int CNT_W         = 16
) (
   input  logic                   clk156_25,
   input  logic                   reset,
   xaui_link_reset_ctrl_if.master link
);

   typedef enum logic [2:0] {
      RST_HOLD   = 3'd0,
      WAIT_ALIGN = 3'd1,
      STABLE_CHK = 3'd2,
      LINK_UP    = 3'd3,
      FAIL       = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] timer;
   logic [CNT_W-1:0] timer_nxt;
   logic [3:0]       retry_q;
   logic [3:0]       retry_nxt;
   logic             good;

   assign good = (&link.lane_sync) & link.align_status;

   // Next-state decode; a failed attempt either retries or latches FAIL once the budget is spent.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer + CNT_W'(1);
      retry_nxt = retry_q;
      if (link.soft_reset_req) begin
         state_nxt = RST_HOLD;
         timer_nxt = '0;
         retry_nxt = '0;
      end else begin
         case (state)
            RST_HOLD: begin
               if (timer == HOLD_LAST) begin
                  state_nxt = WAIT_ALIGN;
                  timer_nxt = '0;
               end
            end
            WAIT_ALIGN: begin
               if (good) begin
                  state_nxt = STABLE_CHK;
                  timer_nxt = '0;
               end else if (timer == SETTLE_LAST) begin
                  timer_nxt = '0;
                  if (retry_q == RETRY_MAX) begin
                     state_nxt = FAIL;
                  end else begin
                     state_nxt = RST_HOLD;
                     retry_nxt = retry_q + 4'd1;
                  end
               end
            end
            STABLE_CHK: begin
               if (!good) begin
                  timer_nxt = '0;
                  if (retry_q == RETRY_MAX) begin
                     state_nxt = FAIL;
                  end else begin
                     state_nxt = RST_HOLD;
                     retry_nxt = retry_q + 4'd1;
                  end
               end else if (timer == STABLE_LAST) begin
                  state_nxt = LINK_UP;
                  timer_nxt = '0;
                  retry_nxt = '0;
               end
            end
            LINK_UP: begin
               // Timer is idle here; hold it so it cannot wrap during a long link-up.
               timer_nxt = timer;
               if (!good) begin
                  state_nxt = RST_HOLD;
                  timer_nxt = '0;
               end
            end
            FAIL: begin
               timer_nxt = timer;
            end
            default: begin
               state_nxt = RST_HOLD;
               timer_nxt = '0;
            end
         endcase
      end
   end

   // State, timer and retry registers plus Moore outputs decoded from the next state.
   always_ff @(posedge clk156_25) begin
      if (reset) begin
         state           <= RST_HOLD;
         timer           <= '0;
         retry_q         <= '0;
         link.xaui_reset <= 1'b1;
         link.link_up    <= 1'b0;
         link.link_fail  <= 1'b0;
         link.ctrl_state <= RST_HOLD;
      end else begin
         state           <= state_nxt;
         timer           <= timer_nxt;
         retry_q         <= retry_nxt;
         link.xaui_reset <= (state_nxt == RST_HOLD) || (state_nxt == FAIL);
         link.link_up    <= (state_nxt == LINK_UP);
         link.link_fail  <= (state_nxt == FAIL);
         link.ctrl_state <= state_nxt;
      end
   end

   assign link.retry_count = retry_q;

endmodule

// File: tb/tb_xaui_link_reset_ctrl.sv
// Bench for the XAUI bring-up sequencer: directed scenarios plus randomized link status.
// Latency: outputs are compared every cycle on the falling edge against a phase/age model.
// Backpressure: not applicable; stimulus is applied one value per cycle.
module tb_xaui_link_reset_ctrl;
   localparam int HOLD   = 16;
   localparam int SETTLE = 1024;
   localparam int STABLE = 256;
   localparam int MAXR   = 7;

   logic clk;
   logic reset;
   xaui_link_reset_ctrl_if lif ();

   xaui_link_reset_ctrl #(
      .HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE), .STABLE_CYCLES(STABLE),
      .MAX_RETRIES(MAXR), .CNT_W(16)
   ) dut (
      .clk156_25(clk),
      .reset(reset),
      .link(lif)
   );

   int n_cmp = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: phase 0=hold,1=wait,2=stable check,3=up,4=fail; age = cycles spent in phase.
   int m_phase = 0;
   int m_age = 0;
   int m_retries = 0;
   bit m_valid = 1'b0;

   // Advance the model on every rising edge from the inputs presented during the cycle.
   always @(posedge clk) begin
      int  ph, ag, rt;
      bit  g, failed;
      ph = m_phase; ag = m_age; rt = m_retries; failed = 1'b0;
      g = (lif.lane_sync == 4'hF) && (lif.align_status == 1'b1);
      if (reset) begin
         ph = 0; ag = 0; rt = 0;
      end else if (lif.soft_reset_req) begin
         ph = 0; ag = 0; rt = 0;
      end else begin
         ag = ag + 1;
         case (ph)
            0: if (ag == HOLD) begin ph = 1; ag = 0; end
            1: if (g) begin ph = 2; ag = 0; end
               else if (ag == SETTLE) failed = 1'b1;
            2: if (!g) failed = 1'b1;
               else if (ag == STABLE) begin ph = 3; ag = 0; rt = 0; end
            3: if (!g) begin ph = 0; ag = 0; end
            default: ;
         endcase
         if (failed) begin
            ag = 0;
            if (rt >= MAXR) ph = 4;
            else begin rt = rt + 1; ph = 0; end
         end
      end
      m_phase   <= ph;
      m_age     <= ag;
      m_retries <= rt;
      m_valid   <= m_valid | reset;
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         logic exp_xr, exp_up, exp_fail;
         exp_xr   = (m_phase == 0) || (m_phase == 4);
         exp_up   = (m_phase == 3);
         exp_fail = (m_phase == 4);
         n_cmp = n_cmp + 1;
         if (lif.xaui_reset !== exp_xr || lif.link_up !== exp_up || lif.link_fail !== exp_fail ||
             lif.retry_count !== 4'(m_retries) || lif.ctrl_state !== 3'(m_phase)) begin
            n_err = n_err + 1;
            $display("FAIL model_cmp t=%0t got xr=%b up=%b fail=%b rc=%0d st=%0d want xr=%b up=%b fail=%b rc=%0d st=%0d",
                     $time, lif.xaui_reset, lif.link_up, lif.link_fail, lif.retry_count, lif.ctrl_state,
                     exp_xr, exp_up, exp_fail, m_retries, m_phase);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp = n_cmp + 1;
      if (act != exp) begin
         n_err = n_err + 1;
         $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_good(input bit g);
      if (g) begin
         lif.lane_sync = 4'hF; lif.align_status = 1'b1;
      end else begin
         lif.lane_sync = 4'($urandom); lif.align_status = 1'($urandom);
         if (lif.lane_sync == 4'hF && lif.align_status) lif.lane_sync[$urandom_range(0, 3)] = 1'b0;
      end
   endtask

   // Leaves the caller at the falling edge right after the last reset edge (cycle 0).
   task automatic do_reset(input bit g);
      @(negedge clk);
      reset = 1'b1; lif.soft_reset_req = 1'b0; set_good(g);
      cyc(2);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; lif.soft_reset_req = 1'b0; lif.lane_sync = 4'h0; lif.align_status = 1'b0;

      // Clean bring-up with good from cycle 0.
      do_reset(1'b1);
      chk("rst_xaui_reset", lif.xaui_reset, 1);
      chk("rst_link_up", lif.link_up, 0);
      chk("rst_link_fail", lif.link_fail, 0);
      chk("rst_retry", lif.retry_count, 0);
      chk("rst_state", lif.ctrl_state, 0);
      cyc(15);  chk("t1_xr_c15", lif.xaui_reset, 1);
      cyc(1);   chk("t1_xr_c16", lif.xaui_reset, 0);
      cyc(256); chk("t1_up_c272", lif.link_up, 0);
      cyc(1);   chk("t1_up_c273", lif.link_up, 1);
      chk("t1_retry", lif.retry_count, 0);

      // Link never comes good: eight timeouts then FAIL, cleared by a soft reset pulse.
      do_reset(1'b0);
      cyc(1040); chk("t2_retry_1", lif.retry_count, 1);
      cyc(1040 * 6); chk("t2_retry_7", lif.retry_count, 7);
      cyc(1039); chk("t2_nofail_yet", lif.link_fail, 0);
      cyc(1);
      chk("t2_link_fail", lif.link_fail, 1);
      chk("t2_xr_fail", lif.xaui_reset, 1);
      chk("t2_state_fail", lif.ctrl_state, 4);
      cyc(20); chk("t2_fail_sticky", lif.link_fail, 1);
      lif.soft_reset_req = 1'b1;
      cyc(1); lif.soft_reset_req = 1'b0;
      chk("t2_sr_state", lif.ctrl_state, 0);
      chk("t2_sr_fail", lif.link_fail, 0);
      chk("t2_sr_retry", lif.retry_count, 0);

      // Single-lane glitch at STABLE_CHK cycle 100, then a clean attempt (covers LINK_UP drop too).
      do_reset(1'b1);
      cyc(117); lif.lane_sync = 4'b1011;
      cyc(1);   set_good(1'b1);
      chk("t3_retry_1", lif.retry_count, 1);
      chk("t3_state_hold", lif.ctrl_state, 0);
      cyc(272); chk("t3_up_c390", lif.link_up, 0);
      cyc(1);   chk("t3_up_c391", lif.link_up, 1);
      chk("t3_retry_0", lif.retry_count, 0);
      lif.align_status = 1'b0;
      cyc(1); lif.align_status = 1'b1;
      chk("t4_up_drop", lif.link_up, 0);
      chk("t4_xr_rise", lif.xaui_reset, 1);
      cyc(15);  chk("t4_xr_c15", lif.xaui_reset, 1);
      cyc(1);   chk("t4_xr_low", lif.xaui_reset, 0);
      cyc(257); chk("t4_relink", lif.link_up, 1);
      chk("t4_retry", lif.retry_count, 0);

      // Good arrives exactly on the last settle cycle.
      do_reset(1'b0);
      cyc(1039); set_good(1'b1);
      cyc(1);
      chk("t5_state", lif.ctrl_state, 2);
      chk("t5_retry", lif.retry_count, 0);

      // Soft reset mid-hold and mid-stability-check restarts the full hold.
      do_reset(1'b1);
      cyc(8); lif.soft_reset_req = 1'b1;
      cyc(1); lif.soft_reset_req = 1'b0;
      chk("t6a_state", lif.ctrl_state, 0);
      cyc(15); chk("t6a_xr_c24", lif.xaui_reset, 1);
      cyc(1);  chk("t6a_xr_c25", lif.xaui_reset, 0);
      cyc(50); chk("t6b_in_chk", lif.ctrl_state, 2);
      lif.soft_reset_req = 1'b1;
      cyc(1); lif.soft_reset_req = 1'b0;
      chk("t6b_xr_rise", lif.xaui_reset, 1);
      cyc(15); chk("t6b_xr_c15", lif.xaui_reset, 1);
      cyc(1);  chk("t6b_xr_low", lif.xaui_reset, 0);

      // Randomized status in segments of differing link quality; the model checks every cycle.
      for (int seg = 0; seg < 8; seg++) begin
         int mode;
         mode = $urandom_range(0, 2);
         for (int c = 0; c < 3000; c++) begin
            bit g;
            case (mode)
               0: g = ($urandom_range(0, 499) != 0);
               1: g = ($urandom_range(0, 199) == 0);
               default: g = $urandom_range(0, 1) != 0;
            endcase
            set_good(g);
            lif.soft_reset_req = ($urandom_range(0, 2999) == 0);
            reset = ($urandom_range(0, 7999) == 0);
            cyc(1);
         end
      end
      reset = 1'b0; lif.soft_reset_req = 1'b0;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
